// File: rtl/qpp_interleave_sched_pkg.sv
// Shared constants and FSM encoding for the QPP interleave address sequencer.
package qpp_interleave_sched_pkg;
   localparam int ADDR_W_DEF = 13;
   localparam int ROW_W_DEF  = 10;
   localparam int NBANK      = 8;
   localparam int KMAX       = 6144;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_RUN,
      ST_FIN
   } state_t;
endpackage

// File: rtl/qpp_interleave_sched_if.sv
// Interleaved address stream: valid/ready handshake plus address, bank select and row.
interface qpp_interleave_sched_if
   import qpp_interleave_sched_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ROW_W  = ROW_W_DEF
);
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] inter_addr;
   logic [2:0]        resort_id;
   logic [ROW_W-1:0]  row_addr;
   logic              out_last;

   modport master (
      output out_valid, inter_addr, resort_id, row_addr, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, inter_addr, resort_id, row_addr, out_last,
      output out_ready
   );
endinterface

// File: rtl/qpp_addmod.sv
// Combinational (a+b) mod k for operands already below k; one conditional subtract.
module qpp_addmod
   import qpp_interleave_sched_pkg::*;
#(
   parameter int W = ADDR_W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] k,
   output logic [W-1:0] sum
);
   logic [W:0] raw;
   logic [W:0] red;

   always_comb begin
      raw = {1'b0, a} + {1'b0, b};
      red = raw - {1'b0, k};
      sum = (raw >= {1'b0, k}) ? red[W-1:0] : raw[W-1:0];
   end
endmodule

// File: rtl/qpp_interleave_sched.sv
// QPP interleaved address sequencer with bank/row split; first address 9 cycles after start,
// out_ready=0 freezes all stream outputs. Optional natural-order mode under INTLV_BYPASS_EN.
module qpp_interleave_sched
   import qpp_interleave_sched_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ROW_W  = ROW_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ADDR_W-1:0]             k_len,
   input  logic [ADDR_W-1:0]             f1,
   input  logic [ADDR_W-1:0]             f2,
`ifdef INTLV_BYPASS_EN
   input  logic                          bypass,
`endif
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   qpp_interleave_sched_if.master        stream
);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] K_LIMIT = ADDR_W'(KMAX);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] k_r, f1_r, f2_r;
   logic [ADDR_W-1:0] pi, g, d, idx, acc, len, acc_sum;
   logic [ADDR_W-1:0] thr [0:NBANK-1];
   logic [2:0]        cnt;
   logic [2:0]        bank_r, bank_nxt;
   logic [ROW_W-1:0]  row_r, row_nxt;
   logic [ADDR_W-1:0] pa, pb, ga, gb, pi_sum, g_sum, pi_nxt;
   logic              fire, last, k_bad;
`ifdef INTLV_BYPASS_EN
   logic              byp_r;
`endif

   assign len     = k_r >> 3;
   assign acc_sum = acc + len;
   assign k_bad   = (k_r == '0) || (k_r[2:0] != 3'd0) || (k_r > K_LIMIT);
   assign last    = (idx == k_r - ONE);
   assign fire    = (state == ST_RUN) && stream.out_ready;

   // During SETUP the two adders derive g0=(f1+f2) mod K and d=(2*f2) mod K.
   always_comb begin
      if (state == ST_SETUP) begin
         pa = f1_r; pb = f2_r;
         ga = f2_r; gb = f2_r;
      end else begin
         pa = pi;   pb = g;
         ga = g;    gb = d;
      end
   end

   qpp_addmod #(.W(ADDR_W)) u_add_pi (.a(pa), .b(pb), .k(k_r), .sum(pi_sum));
   qpp_addmod #(.W(ADDR_W)) u_add_g  (.a(ga), .b(gb), .k(k_r), .sum(g_sum));

`ifdef INTLV_BYPASS_EN
   assign pi_nxt = byp_r ? idx + ONE : pi_sum;
`else
   assign pi_nxt = pi_sum;
`endif

   always_comb begin
      bank_nxt = '0;
      for (int j = 1; j < NBANK; j++) begin
         if (thr[j] <= pi_nxt) bank_nxt = bank_nxt + 3'd1;
      end
      row_nxt = ROW_W'(pi_nxt - thr[bank_nxt]);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      busy             = (state != ST_IDLE);
      done             = (state == ST_FIN);
      stream.out_valid = (state == ST_RUN);
      stream.out_last  = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SETUP;
         ST_SETUP: begin
            if (cnt == 3'd0 && k_bad) state_nxt = ST_FIN;
            else if (cnt == 3'd7)     state_nxt = ST_RUN;
         end
         ST_RUN: begin
            stream.out_last = last;
            if (fire && last) state_nxt = ST_FIN;
         end
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign stream.inter_addr = pi;
   assign stream.resort_id  = bank_r;
   assign stream.row_addr   = row_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         err    <= 1'b0;
         k_r    <= '0;
         f1_r   <= '0;
         f2_r   <= '0;
         pi     <= '0;
         g      <= '0;
         d      <= '0;
         idx    <= '0;
         acc    <= '0;
         cnt    <= '0;
         bank_r <= '0;
         row_r  <= '0;
         for (int j = 0; j < NBANK; j++) thr[j] <= '0;
`ifdef INTLV_BYPASS_EN
         byp_r  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               k_r  <= k_len;
               f1_r <= f1;
               f2_r <= f2;
               err  <= 1'b0;
               cnt  <= '0;
               acc  <= '0;
`ifdef INTLV_BYPASS_EN
               byp_r <= bypass;
`endif
            end
            ST_SETUP: begin
               cnt <= cnt + 3'd1;
               // One threshold per cycle: T[cnt+1] = (cnt+1)*L.
               if (cnt != 3'd7) begin
                  acc              <= acc_sum;
                  thr[cnt + 3'd1]  <= acc_sum;
               end
               g      <= pi_sum;
               d      <= g_sum;
               pi     <= '0;
               idx    <= '0;
               bank_r <= '0;
               row_r  <= '0;
               if (cnt == 3'd0 && k_bad) err <= 1'b1;
            end
            ST_RUN: if (fire) begin
               pi     <= pi_nxt;
               g      <= g_sum;
               idx    <= idx + ONE;
               bank_r <= bank_nxt;
               row_r  <= row_nxt;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/qpp_interleave_sched.md
Name: qpp_interleave_sched

Overview:
- Sequencer for the 8-way bank-select interleave mux in the turbo decoder.
- Generates the QPP interleaved address stream pi(i) = (f1*i + f2*i^2) mod K for i = 0..K-1, one address per accepted cycle.
- Splits each address into a 3-bit bank id (resort id) and a row address within the bank. The frame is split into 8 contiguous sub-blocks of length L = K/8.
- Sits between the SISO control FSM and the extrinsic memories. Its resort_id output drives the interleave mux select.

Parameters:
- ADDR_W, 13, width of K, f1, f2 and interleaved address (K up to 6144).
- ROW_W, 10, row address width; must equal ADDR_W-3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE
- k_len  in  ADDR_W  frame length K; sampled on accepted start
- f1  in  ADDR_W  QPP coefficient f1 (< K); sampled on accepted start
- f2  in  ADDR_W  QPP coefficient f2 (< K); sampled on accepted start
- out_ready  in  1  consumer accepts current address
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame end
- err  out  1  sticky until next accepted start: illegal K
- out_valid  out  1  address outputs valid
- inter_addr  out  ADDR_W  pi(i)
- resort_id  out  3  bank = floor(pi(i)/L)
- row_addr  out  ROW_W  pi(i) - resort_id*L
- out_last  out  1  high with i = K-1

Behaviour:
- Reset: all outputs 0; FSM to IDLE; err cleared. Reset mid-frame aborts immediately and emits no done.
- FSM states: IDLE, SETUP, RUN, FIN.
- IDLE:
  - start=1 latches K, f1 and f2, clears err, and moves to SETUP.
  - If K=0, or K mod 8 != 0, or K > 6144: set err and go to FIN. No addresses are emitted.
- SETUP (exactly 8 cycles):
  - L = K>>3.
  - Thresholds T[j] = j*L for j=1..7, built by accumulation, one add per cycle.
  - Compute g0 = (f1+f2) mod K and d = (2*f2) mod K.
  - pi = 0, i = 0.
- RUN:
  - out_valid=1 with the registered pi, resort_id, row_addr and i.
  - resort_id = number of thresholds T[j] <= pi.
  - row_addr = pi - T[resort_id], where T[0] = 0.
  - Advance only on out_valid & out_ready:
    - pi <= (pi+g) mod K
    - g <= (g+d) mod K
    - i <= i+1
  - Modular add is sum = a+b followed by one conditional subtract of K; operands are always < K. Internal sum is ADDR_W+1 bits.
  - out_ready=0 holds every output stable; there is no bubble on release.
  - out_last = (i == K-1). The handshake on the last address moves to FIN.
- FIN: done=1 for one cycle, out_valid=0, busy=0 next cycle, return to IDLE.
- Timing: start accepted at edge t → busy at t+1 → first out_valid at t+9.
- Throughput: 1 address/cycle with out_ready held high.
- start while busy is ignored. Inputs changing during a frame have no effect.

Optional Feature:
- Macro INTLV_BYPASS_EN.
- Defined: adds input port bypass (1 bit), sampled with start.
  - When set, RUN emits natural order pi(i)=i; SETUP, bank split, handshake and timing are unchanged.
- Undefined: no bypass port; QPP order only.

Decomposition:
- Shared package holds:
  - ADDR_W and ROW_W defaults
  - NBANK=8
  - KMAX=6144
  - FSM state encoding for IDLE/SETUP/RUN/FIN
- One sub-module, qpp_addmod: combinational (a+b) mod K. Two instances are used, for pi and for g.
- Threshold compare and row subtract stay inline.

Test Plan:
- K=40, f1=3, f2=10, out_ready=1 → inter_addr 0,13,6,19,…
  - resort_id/row_addr: (0,0), (2,3), (1,1), (3,4).
  - out_last on the 40th beat; done one cycle later.
  - First out_valid exactly 9 cycles after start.
  - The 40 addresses are a permutation of 0..39.
- Same frame with out_ready toggled pseudo-randomly → identical address sequence; outputs stable across stalled cycles.
- K=44 → err=1, zero out_valid beats, done pulse two cycles after start.
- K=0 → same error response as K=44.
- start pulsed during RUN → ignored; sequence unchanged.
- rst asserted mid-frame at beat 10 → all outputs 0 next cycle, no done. A new start with K=6144, f1=263, f2=480 runs a full frame and every bank receives exactly 768 addresses.
- INTLV_BYPASS_EN defined, bypass=1, K=40 → inter_addr 0..39; resort_id = i/5; row_addr = i mod 5.
